uart_rx_deser: RTL and testbench

// - UART receive front end feeding the debug unit: deserialises the 8N1 line from the host PC into bytes.
// - Presents each byte with a level ready flag. The flag is held until the debug unit clears it with its rx-reset output.
// - Generates its own 16x oversampling tick from the system clock. Needs no external baud module.

---
 rtl/uart_rx_deser_if.sv | 33 +++
 rtl/uart_rx_deser.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deser_if.sv
// Signal bundle between the UART receive front end and the debug unit.
// The deserialiser uses the slave modport; the host/debug side uses master.
interface uart_rx_deser_if #(
  parameter int SIZE_TRAMA = 8
);
  logic                  i_rx;
  logic                  i_rx_reset;
  logic [SIZE_TRAMA-1:0] o_rx_data;
  logic                  o_rx_flag_ready;
  logic                  o_rx_overrun;
  logic                  o_frame_error;
  logic                  o_parity_error;

  modport slave (
    input  i_rx,
    input  i_rx_reset,
    output o_rx_data,
    output o_rx_flag_ready,
    output o_rx_overrun,
    output o_frame_error,
    output o_parity_error
  );

  modport master (
    output i_rx,
    output i_rx_reset,
    input  o_rx_data,
    input  o_rx_flag_ready,
    input  o_rx_overrun,
    input  o_frame_error,
    input  o_parity_error
  );
endinterface

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser with its own oversampling tick and a level ready flag.
// Optional parity check is compiled in with `define UART_RX_PARITY_EN (PARITY_ODD=1 selects odd).
module uart_rx_deser #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 19_200,
  parameter int SIZE_TRAMA = 8,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic           i_clk,
  input  logic           i_reset,
  uart_rx_deser_if.slave bus
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BW  = (SIZE_TRAMA > 1) ? $clog2(SIZE_TRAMA) : 1;

  localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
  localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(SIZE_TRAMA - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [OSW-1:0]        os_cnt_q, os_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SIZE_TRAMA-1:0] shift_q, shift_d;
  logic [SIZE_TRAMA-1:0] rx_data_q, rx_data_d;
  logic                  flag_q, flag_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                  parity_err_q, parity_err_d;
  logic                  par_bad_q, par_bad_d;
  logic                  parity_evt;
`endif

  logic rx_s;
  logic tick;
  logic sample_full;
  logic commit;
  logic frame_evt;

  always_comb begin
    rx_s        = sync_q[1];
    sync_d      = {sync_q[0], bus.i_rx};
    tick        = (tick_cnt_q == TICK_LAST);
    sample_full = tick && (os_cnt_q == OS_LAST);
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    os_cnt_d    = tick ? os_cnt_q + 1'b1 : os_cnt_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    commit      = 1'b0;
    frame_evt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    parity_evt  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        os_cnt_d = '0;
        if (!rx_s) begin
          // Realign the tick phase to the detected falling edge.
          state_d    = ST_START;
          tick_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d  = 1'b0;
`endif
        end
      end

      ST_START: begin
        if (tick && (os_cnt_q == OS_HALF)) begin
          os_cnt_d  = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (sample_full) begin
          os_cnt_d  = '0;
          shift_d   = {rx_s, shift_q[SIZE_TRAMA-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample_full) begin
          os_cnt_d   = '0;
          parity_evt = (^shift_q) ^ rx_s ^ PARITY_ODD;
          par_bad_d  = parity_evt;
          state_d    = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (sample_full) begin
          os_cnt_d = '0;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            commit = !par_bad_q;
`else
            commit = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            frame_evt = 1'b1;
            state_d   = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        os_cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A clear loses to anything that is being set in the same cycle.
    rx_data_d   = rx_data_q;
    flag_d      = flag_q & ~bus.i_rx_reset;
    overrun_d   = overrun_q & ~bus.i_rx_reset;
    frame_err_d = (frame_err_q & ~bus.i_rx_reset) | frame_evt;
`ifdef UART_RX_PARITY_EN
    parity_err_d = (parity_err_q & ~bus.i_rx_reset) | parity_evt;
`endif
    if (commit) begin
      rx_data_d = shift_q;
      flag_d    = 1'b1;
      overrun_d = overrun_d | (flag_q & ~bus.i_rx_reset);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      sync_q       <= '1;
      tick_cnt_q   <= '0;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      flag_q       <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      tick_cnt_q   <= tick_cnt_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      flag_q       <= flag_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  assign bus.o_rx_data       = rx_data_q;
  assign bus.o_rx_flag_ready = flag_q;
  assign bus.o_rx_overrun    = overrun_q;
  assign bus.o_frame_error   = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.o_parity_error  = parity_err_q;
`else
  assign bus.o_parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: line-level frame model predicts every output each cycle,
// plus literal pins on the directed scenarios. Honours `UART_RX_PARITY_EN (even parity).
module tb_uart_rx_deser;
  localparam int CLK_FREQ   = 640;
  localparam int BAUD_RATE  = 10;
  localparam int SIZE_TRAMA = 8;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLK    = CLK_FREQ / BAUD_RATE;
  localparam int MID        = BIT_CLK / 2;
  localparam int LAT        = 3;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX   = SIZE_TRAMA + 2;
  localparam int LIT_COMMIT = 675;  // 32 + 10*64 + 3
`else
  localparam int STOP_IDX   = SIZE_TRAMA + 1;
  localparam int LIT_COMMIT = 611;  // 32 + 9*64 + 3
`endif
  localparam int SEL_DATA = 0;
  localparam int SEL_FLAG = 1;
  localparam int SEL_OV   = 2;
  localparam int SEL_FE   = 3;
  localparam int SEL_PE   = 4;
  localparam int SEL_RISE = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] req;
  } pin_t;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  logic dir_clr = 1'b0;
  logic rnd_clr = 1'b0;
  bit   rnd_en  = 1'b0;
`ifdef UART_RX_PARITY_EN
  bit   inject_bad_par = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_rise = -1;
  logic prev_flag = 1'b0;

  logic [SIZE_TRAMA-1:0] exp_data = '0;
  logic exp_flag = 1'b0, exp_ov = 1'b0, exp_fe = 1'b0, exp_pe = 1'b0;

  int                    ev_kind [int];
  logic [SIZE_TRAMA-1:0] ev_data [int];
  pin_t                  pin_q [$];

  uart_rx_deser_if #(.SIZE_TRAMA(SIZE_TRAMA)) bus ();

  uart_rx_deser #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .SIZE_TRAMA(SIZE_TRAMA),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  assign bus.i_rx_reset = dir_clr | rnd_clr;

  always #5 i_clk = ~i_clk;

  // Model: each frame's outcome lands LAT clocks after its line-level mid-bit instant.
  always @(posedge i_clk) begin
    int   kd;
    logic rr;
    cyc = cyc + 1;
    rr  = bus.i_rx_reset;
    if (i_reset) begin
      exp_data = '0;
      exp_flag = 1'b0;
      exp_ov   = 1'b0;
      exp_fe   = 1'b0;
      exp_pe   = 1'b0;
      ev_kind.delete();
      ev_data.delete();
    end else begin
      kd = 0;
      if (ev_kind.exists(cyc)) kd = ev_kind[cyc];
      if (kd[0]) begin
        exp_ov   = rr ? 1'b0 : (exp_ov | exp_flag);
        exp_flag = 1'b1;
        exp_data = ev_data[cyc];
      end else if (rr) begin
        exp_flag = 1'b0;
        exp_ov   = 1'b0;
      end
      exp_fe = kd[1] ? 1'b1 : (rr ? 1'b0 : exp_fe);
      exp_pe = kd[2] ? 1'b1 : (rr ? 1'b0 : exp_pe);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  always @(negedge i_clk) begin
    pin_t        p;
    logic [31:0] act;
    if (cyc > 0) begin
      chk("rx_data",      32'(bus.o_rx_data),       32'(exp_data));
      chk("flag_ready",   32'(bus.o_rx_flag_ready), 32'(exp_flag));
      chk("overrun",      32'(bus.o_rx_overrun),    32'(exp_ov));
      chk("frame_error",  32'(bus.o_frame_error),   32'(exp_fe));
      chk("parity_error", 32'(bus.o_parity_error),  32'(exp_pe));
    end
    if (bus.o_rx_flag_ready === 1'b1 && prev_flag !== 1'b1) last_rise = cyc;
    prev_flag = bus.o_rx_flag_ready;
    while (pin_q.size() > 0) begin
      p = pin_q.pop_front();
      case (p.sel)
        SEL_DATA: act = 32'(bus.o_rx_data);
        SEL_FLAG: act = 32'(bus.o_rx_flag_ready);
        SEL_OV:   act = 32'(bus.o_rx_overrun);
        SEL_FE:   act = 32'(bus.o_frame_error);
        SEL_PE:   act = 32'(bus.o_parity_error);
        default:  act = 32'(last_rise);
      endcase
      chk(p.tag, act, p.req);
    end
  end

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      rnd_clr = rnd_en && ($urandom_range(0, 63) == 0);
    end
  end

  function automatic void add_ev(input int k, input int kind, input logic [SIZE_TRAMA-1:0] d);
    if (ev_kind.exists(k)) ev_kind[k] = ev_kind[k] | kind;
    else ev_kind[k] = kind;
    if (kind == 1) ev_data[k] = d;
  endfunction

  task automatic pin(input string tag, input int sel, input int req);
    pin_t p;
    p.tag = tag;
    p.sel = sel;
    p.req = 32'(req);
    pin_q.push_back(p);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic clr_pulse();
    dir_clr = 1'b1;
    step(1);
    dir_clr = 1'b0;
  endtask

  // Drives one frame starting now; schedules its predicted outcome for the model.
  task automatic send_frame(input logic [SIZE_TRAMA-1:0] b, input bit stop_ok, input int hold_low);
    int n;
    int k_stop;
`ifdef UART_RX_PARITY_EN
    logic par;
    par = (^b) ^ inject_bad_par;
`endif
    n      = cyc;
    k_stop = n + MID + BIT_CLK * STOP_IDX + LAT;
`ifdef UART_RX_PARITY_EN
    if (inject_bad_par) add_ev(n + MID + BIT_CLK * (SIZE_TRAMA + 1) + LAT, 4, '0);
    if (stop_ok && !inject_bad_par) add_ev(k_stop, 1, b);
`else
    if (stop_ok) add_ev(k_stop, 1, b);
`endif
    if (!stop_ok) add_ev(k_stop, 2, '0);
    bus.i_rx = 1'b0;
    step(BIT_CLK);
    for (int i = 0; i < SIZE_TRAMA; i++) begin
      bus.i_rx = b[i];
      step(BIT_CLK);
    end
`ifdef UART_RX_PARITY_EN
    bus.i_rx = par;
    step(BIT_CLK);
`endif
    bus.i_rx = stop_ok;
    step(BIT_CLK);
    if (!stop_ok) step(hold_low);
    bus.i_rx = 1'b1;
  endtask

  initial begin
    int n0;
    logic [SIZE_TRAMA-1:0] rb;
    bit ok;
    bus.i_rx = 1'b1;
    step(4);
    i_reset = 1'b0;
    pin("reset_data", SEL_DATA, 0);
    pin("reset_flag", SEL_FLAG, 0);
    pin("reset_ov",   SEL_OV,   0);
    pin("reset_fe",   SEL_FE,   0);
    pin("reset_pe",   SEL_PE,   0);
    step(10);

    n0 = cyc;
    send_frame(8'h63, 1'b1, 0);
    step(4);
    pin("c_data",    SEL_DATA, 'h63);
    pin("c_flag",    SEL_FLAG, 1);
    pin("c_fe",      SEL_FE,   0);
    pin("c_latency", SEL_RISE, n0 + LIT_COMMIT);
    clr_pulse();
    pin("c_clr_flag", SEL_FLAG, 0);

    send_frame(8'h73, 1'b1, 0);
    step(4);
    pin("s_data", SEL_DATA, 'h73);
    pin("s_ov",   SEL_OV,   0);
    clr_pulse();
    pin("s_clr_flag", SEL_FLAG, 0);
    pin("s_kept_data", SEL_DATA, 'h73);

    send_frame(8'h64, 1'b1, 0);
    send_frame(8'h6E, 1'b1, 0);
    step(4);
    pin("ovr_data", SEL_DATA, 'h6E);
    pin("ovr_flag", SEL_FLAG, 1);
    pin("ovr_ov",   SEL_OV,   1);
    clr_pulse();
    pin("ovr_clr_flag", SEL_FLAG, 0);
    pin("ovr_clr_ov",   SEL_OV,   0);

    bus.i_rx = 1'b0;
    step(20);
    bus.i_rx = 1'b1;
    step(100);
    pin("glitch_flag", SEL_FLAG, 0);
    pin("glitch_fe",   SEL_FE,   0);

    send_frame(8'hFF, 1'b0, 200);
    step(64);
    pin("brk_fe",   SEL_FE,   1);
    pin("brk_flag", SEL_FLAG, 0);
    send_frame(8'h01, 1'b1, 0);
    step(4);
    pin("after_brk_data", SEL_DATA, 'h01);
    pin("after_brk_flag", SEL_FLAG, 1);

    // Clear lands exactly on the commit cycle of 0xA5 while 0x01 is still unconsumed.
    n0 = cyc;
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        step(MID + BIT_CLK * STOP_IDX + LAT - 1);
        dir_clr = 1'b1;
        step(1);
        dir_clr = 1'b0;
      end
    join
    step(4);
    pin("race_data", SEL_DATA, 'hA5);
    pin("race_flag", SEL_FLAG, 1);
    pin("race_ov",   SEL_OV,   0);
    pin("race_fe",   SEL_FE,   0);

    bus.i_rx = 1'b0;
    step(64);
    bus.i_rx = 1'b1;
    step(64);
    bus.i_rx = 1'b0;
    step(64);
    i_reset  = 1'b1;
    bus.i_rx = 1'b1;
    step(2);
    pin("rst_data", SEL_DATA, 0);
    pin("rst_flag", SEL_FLAG, 0);
    i_reset = 1'b0;
    step(100);
    send_frame(8'h5A, 1'b1, 0);
    step(4);
    pin("post_rst_data", SEL_DATA, 'h5A);
    pin("post_rst_flag", SEL_FLAG, 1);
    clr_pulse();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h63, 1'b1, 0);
    step(4);
    pin("par_ok_flag", SEL_FLAG, 1);
    pin("par_ok_pe",   SEL_PE,   0);
    clr_pulse();
    inject_bad_par = 1'b1;
    send_frame(8'h63, 1'b1, 0);
    inject_bad_par = 1'b0;
    step(4);
    pin("par_bad_pe",   SEL_PE,   1);
    pin("par_bad_flag", SEL_FLAG, 0);
    clr_pulse();
`endif

    rnd_en = 1'b1;
    for (int f = 0; f < 24; f++) begin
      rb = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      inject_bad_par = ($urandom_range(0, 7) == 0);
`endif
      send_frame(rb, ok, $urandom_range(0, 150));
      step(8 + $urandom_range(0, 40));
    end
`ifdef UART_RX_PARITY_EN
    inject_bad_par = 1'b0;
`endif
    rnd_en = 1'b0;
    step(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
